lcd_frame_streamer: RTL

- Parametrised successor to the PCD8544 (Nokia 5110) serial driver.
- Holds no frame image internally. It streams a full frame from an external synchronous framebuffer RAM over the LCD serial bus.
- Runs the panel power-up/init command sequence once after reset, then sends one frame per request or continuously.
- Sits between the game/sprite compositor (which owns the framebuffer) and the LCD pins.

---
 rtl/lcd_frame_streamer_if.sv | 31 +++
 rtl/lcd_frame_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_streamer_if.sv
// rtl/lcd_frame_streamer_if.sv - compositor, framebuffer and LCD pin bundle for lcd_frame_streamer
interface lcd_frame_streamer_if #(
   parameter int ADDR_W = 9
);
   logic              frame_start;
   logic              auto_mode;
   logic              invert;
   logic              ready;
   logic              busy;
   logic              done;
   logic              fb_rd;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_data;
   logic              lcd_rst_n;
   logic              lcd_ce_n;
   logic              lcd_dc;
   logic              lcd_din;
   logic              lcd_sclk;

   modport slave (
      input  frame_start, auto_mode, invert, fb_data,
      output ready, busy, done, fb_rd, fb_addr,
      output lcd_rst_n, lcd_ce_n, lcd_dc, lcd_din, lcd_sclk
   );

   modport master (
      output frame_start, auto_mode, invert, fb_data,
      input  ready, busy, done, fb_rd, fb_addr,
      input  lcd_rst_n, lcd_ce_n, lcd_dc, lcd_din, lcd_sclk
   );
endinterface

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - streams frames from an external framebuffer RAM to a PCD8544-style panel
// Runs the panel init once after reset, then sends header + COLS*PAGES data bytes per frame.
module lcd_frame_streamer #(
   parameter int         COLS       = 84,
   parameter int         PAGES      = 6,
   parameter int         CLK_DIV    = 4,
   parameter int         RST_CYCLES = 16,
   parameter logic [6:0] VOP        = 7'h40,
   parameter logic [2:0] BIAS       = 3'd4,
   parameter int         ADDR_W     = $clog2(COLS*PAGES)
) (
   input  logic                 clk,
   input  logic                 reset,
   lcd_frame_streamer_if.slave  bus
);
   localparam int NBYTES = COLS * PAGES;
   localparam int CNT_W  = (ADDR_W > 3) ? ADDR_W : 3;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NBYTES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);

   localparam logic [2:0] S_RST_HOLD = 3'd0;
   localparam logic [2:0] S_INIT     = 3'd1;
   localparam logic [2:0] S_IDLE     = 3'd2;
   localparam logic [2:0] S_HDR      = 3'd3;
   localparam logic [2:0] S_DATA     = 3'd4;
   localparam logic [2:0] S_END      = 3'd5;

   localparam logic [1:0] P_LOAD0 = 2'd0;
   localparam logic [1:0] P_LOAD1 = 2'd1;
   localparam logic [1:0] P_SHIFT = 2'd2;

   logic [2:0]        state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              sclk_q, sclk_d;
   logic [2:0]        bit_q, bit_d;
   logic [CNT_W-1:0]  byte_q, byte_d;
   logic [7:0]        shift_q, shift_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic              end_q, end_d;
   logic              done_q, done_d;
   logic              inv_q, inv_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;

   logic       in_seq;
   logic       fb_rd;
   logic [7:0] cmd_byte;

   assign in_seq = (state_q == S_INIT) || (state_q == S_HDR) || (state_q == S_DATA);
   assign fb_rd  = (state_q == S_DATA) && (phase_q == P_LOAD0);

   always_comb begin
      cmd_byte = 8'h00;
      if (state_q == S_INIT) begin
         case (byte_q[2:0])
            3'd0:    cmd_byte = 8'h21;
            3'd1:    cmd_byte = {1'b1, VOP};
            3'd2:    cmd_byte = 8'h04;
            3'd3:    cmd_byte = {5'b00010, BIAS};
            3'd4:    cmd_byte = 8'h20;
            default: cmd_byte = 8'h0C;
         endcase
      end else begin
         case (byte_q[1:0])
            2'd0:    cmd_byte = inv_q ? 8'h0D : 8'h0C;
            2'd1:    cmd_byte = 8'h40;
            default: cmd_byte = 8'h80;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      div_d     = div_q;
      sclk_d    = sclk_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      rst_cnt_d = rst_cnt_q;
      end_d     = end_q;
      done_d    = 1'b0;
      inv_d     = inv_q;
      fb_addr_d = fb_addr_q;

      case (state_q)
         S_RST_HOLD: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_INIT;
               phase_d = P_LOAD0;
               byte_d  = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (bus.frame_start || bus.auto_mode) begin
               state_d = S_HDR;
               phase_d = P_LOAD0;
               byte_d  = '0;
               inv_d   = bus.invert;
            end
         end
         S_END: begin
            if (end_q) begin
               state_d = S_IDLE;
               end_d   = 1'b0;
               done_d  = 1'b1;
            end else begin
               end_d = 1'b1;
            end
         end
         S_INIT, S_HDR, S_DATA: ;
         default: state_d = S_RST_HOLD;
      endcase

      // Byte engine: 2 load cycles, then 8 bits of CLK_DIV low + CLK_DIV high sclk.
      if (in_seq) begin
         case (phase_q)
            P_LOAD0: begin
               phase_d = P_LOAD1;
               if (state_q == S_DATA) begin
                  fb_addr_d = byte_q[ADDR_W-1:0];
               end
            end
            P_LOAD1: begin
               phase_d = P_SHIFT;
               div_d   = '0;
               sclk_d  = 1'b0;
               bit_d   = 3'd0;
               shift_d = (state_q == S_DATA) ? bus.fb_data : cmd_byte;
            end
            default: begin
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (!sclk_q) begin
                     sclk_d = 1'b1;
                  end else begin
                     sclk_d  = 1'b0;
                     shift_d = {shift_q[6:0], 1'b0};
                     if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        phase_d = P_LOAD0;
                        case (state_q)
                           S_INIT: begin
                              if (byte_q == CNT_W'(5)) begin
                                 state_d = S_IDLE;
                                 byte_d  = '0;
                              end else begin
                                 byte_d = byte_q + 1'b1;
                              end
                           end
                           S_HDR: begin
                              if (byte_q == CNT_W'(2)) begin
                                 state_d = S_DATA;
                                 byte_d  = '0;
                              end else begin
                                 byte_d = byte_q + 1'b1;
                              end
                           end
                           default: begin
                              if (byte_q == LAST_DATA) begin
                                 state_d = S_END;
                                 end_d   = 1'b0;
                              end else begin
                                 byte_d = byte_q + 1'b1;
                              end
                           end
                        endcase
                     end else begin
                        bit_d = bit_q + 1'b1;
                     end
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_RST_HOLD;
         phase_q   <= P_LOAD0;
         div_q     <= '0;
         sclk_q    <= 1'b0;
         bit_q     <= 3'd0;
         byte_q    <= '0;
         shift_q   <= 8'h00;
         rst_cnt_q <= '0;
         end_q     <= 1'b0;
         done_q    <= 1'b0;
         inv_q     <= 1'b0;
         fb_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         div_q     <= div_d;
         sclk_q    <= sclk_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         rst_cnt_q <= rst_cnt_d;
         end_q     <= end_d;
         done_q    <= done_d;
         inv_q     <= inv_d;
         fb_addr_q <= fb_addr_d;
      end
   end

   // Shifting in zeros leaves din low between bytes and after the last bit.
   assign bus.lcd_rst_n = (state_q != S_RST_HOLD);
   assign bus.lcd_ce_n  = !in_seq;
   assign bus.lcd_dc    = (state_q == S_DATA);
   assign bus.lcd_din   = shift_q[7];
   assign bus.lcd_sclk  = sclk_q;
   assign bus.ready     = (state_q != S_RST_HOLD) && (state_q != S_INIT);
   assign bus.busy      = (state_q == S_HDR) || (state_q == S_DATA);
   assign bus.done      = done_q;
   assign bus.fb_rd     = fb_rd;
   assign bus.fb_addr   = fb_rd ? byte_q[ADDR_W-1:0] : fb_addr_q;
endmodule
